// File: rtl/mux_pkg.sv
// Shared constants and helpers for the arbitrating output multiplexer.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width needed to address n channels, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    int p;
    w = 32'sd1;
    p = 32'sd2;
    while (p < n) begin
      w = w + 32'sd1;
      p = p * 32'sd2;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: scans requests upward from a rotating pointer, wrapping at NUM_IN.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_vld
);

  localparam logic [SEL_W:0] NUM_W  = (SEL_W+1)'(NUM_IN);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W:0]   sum_s;
  logic [SEL_W-1:0] idx_s;

  // Descending scan so the candidate closest to the pointer is written last and wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      sum_s     = {1'b0, ptr_q} + (SEL_W+1)'(k);
      idx_s     = (sum_s >= NUM_W) ? SEL_W'(sum_s - NUM_W) : SEL_W'(sum_s);
      grant     = req[idx_s] ? idx_s : grant;
      grant_vld = grant_vld | req[idx_s];
    end
  end

  // Pointer moves past the winner only when a round-robin transfer is accepted.
  always_comb begin
    if (advance) begin
      ptr_d = (grant == LAST) ? '0 : grant + SEL_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel to one multiplexer with directed or round-robin selection and a single output register.
module arb_mux
  import mux_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic             can_accept_s;
  logic             dir_vld_s;
  logic [SEL_W-1:0] rr_grant_s;
  logic             rr_vld_s;
  logic [SEL_W-1:0] grant_s;
  logic             grant_vld_s;
  logic             load_s;
  logic             advance_s;
  logic [WIDTH-1:0] mux_data_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .advance   (advance_s),
    .grant     (rr_grant_s),
    .grant_vld (rr_vld_s)
  );

  // An out-of-range sel matches no channel, so it can never grant.
  always_comb begin
    can_accept_s = !out_valid_q | out_ready;
    dir_vld_s    = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      dir_vld_s = dir_vld_s | (in_valid[i] & (sel == SEL_W'(i)));
    end
    grant_s     = (mode == MODE_RR) ? rr_grant_s : sel;
    grant_vld_s = (mode == MODE_RR) ? rr_vld_s : dir_vld_s;
    load_s      = grant_vld_s & can_accept_s;
    advance_s   = load_s & (mode == MODE_RR);
    mux_data_s  = '0;
    in_ready    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      mux_data_s  = mux_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s == SEL_W'(i)}});
      in_ready[i] = load_s & (grant_s == SEL_W'(i));
    end
  end

  // Output register next state: refill, drain, or hold.
  always_comb begin
    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data_s;
      out_src_d   = grant_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
    end else begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux in 2-, 3- and 4-channel configurations.
module tb_arb_mux;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic       d2_mode, d2_sel, d2_out_src, d2_out_valid, d2_out_ready;
  logic [9:0] d2_in_data;
  logic [1:0] d2_in_valid, d2_in_ready;
  logic [4:0] d2_out_data;

  logic        d3_mode, d3_out_valid, d3_out_ready;
  logic [1:0]  d3_sel, d3_out_src;
  logic [14:0] d3_in_data;
  logic [2:0]  d3_in_valid, d3_in_ready;
  logic [4:0]  d3_out_data;

  logic        d4_mode, d4_out_valid, d4_out_ready;
  logic [1:0]  d4_sel, d4_out_src;
  logic [19:0] d4_in_data;
  logic [3:0]  d4_in_valid, d4_in_ready;
  logic [4:0]  d4_out_data;

  arb_mux #(.WIDTH(5), .NUM_IN(2), .SEL_W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .mode(d2_mode), .sel(d2_sel), .in_data(d2_in_data),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .out_data(d2_out_data),
    .out_src(d2_out_src), .out_valid(d2_out_valid), .out_ready(d2_out_ready));

  arb_mux #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .mode(d3_mode), .sel(d3_sel), .in_data(d3_in_data),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_src(d3_out_src), .out_valid(d3_out_valid), .out_ready(d3_out_ready));

  arb_mux #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u4 (
    .clk(clk), .rst_n(rst_n), .mode(d4_mode), .sel(d4_sel), .in_data(d4_in_data),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .out_data(d4_out_data),
    .out_src(d4_out_src), .out_valid(d4_out_valid), .out_ready(d4_out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1);
  end

  task automatic test_reset();
    #2;
    n_cmp++; if (d2_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_u2_valid got=%b exp=0", d2_out_valid); end
    n_cmp++; if (d2_out_data !== 5'h00) begin n_err++; $display("FAIL rst_u2_data got=%h exp=00", d2_out_data); end
    n_cmp++; if (d3_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_u3_valid got=%b exp=0", d3_out_valid); end
    n_cmp++; if (d4_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_u4_valid got=%b exp=0", d4_out_valid); end
    n_cmp++; if (d4_out_src !== 2'd0) begin n_err++; $display("FAIL rst_u4_src got=%0d exp=0", d4_out_src); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    d2_mode = 1'b0; d2_sel = 1'b0; d2_in_data = {5'h08, 5'h07}; d2_in_valid = 2'b11; d2_out_ready = 1'b1;
    #1;
    n_cmp++; if (d2_in_ready !== 2'b01) begin n_err++; $display("FAIL dir_rdy0 got=%b exp=01", d2_in_ready); end
    n_cmp++; if (d2_out_valid !== 1'b0) begin n_err++; $display("FAIL dir_lat got=%b exp=0", d2_out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (d2_out_data !== 5'h07) begin n_err++; $display("FAIL dir_data0 got=%h exp=07", d2_out_data); end
    n_cmp++; if (d2_out_src !== 1'b0) begin n_err++; $display("FAIL dir_src0 got=%0d exp=0", d2_out_src); end
    n_cmp++; if (d2_out_valid !== 1'b1) begin n_err++; $display("FAIL dir_vld0 got=%b exp=1", d2_out_valid); end
    d2_sel = 1'b1;
    #1;
    n_cmp++; if (d2_in_ready !== 2'b10) begin n_err++; $display("FAIL dir_rdy1 got=%b exp=10", d2_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d2_out_data !== 5'h08) begin n_err++; $display("FAIL dir_data1 got=%h exp=08", d2_out_data); end
    n_cmp++; if (d2_out_src !== 1'b1) begin n_err++; $display("FAIL dir_src1 got=%0d exp=1", d2_out_src); end
    d2_in_valid = 2'b00;
    @(posedge clk); #1;
    n_cmp++; if (d2_out_valid !== 1'b0) begin n_err++; $display("FAIL dir_drain got=%b exp=0", d2_out_valid); end
    n_cmp++; if (d2_out_data !== 5'h08) begin n_err++; $display("FAIL dir_hold got=%h exp=08", d2_out_data); end
  endtask

  task automatic test_backpressure();
    d2_sel = 1'b0; d2_in_data = {5'h04, 5'h09}; d2_in_valid = 2'b01; d2_out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (d2_out_data !== 5'h09) begin n_err++; $display("FAIL bp_load got=%h exp=09", d2_out_data); end
    d2_out_ready = 1'b0; d2_in_data = {5'h04, 5'h03};
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (d2_in_ready !== 2'b00) begin n_err++; $display("FAIL bp_rdy%0d got=%b exp=00", c, d2_in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (d2_out_data !== 5'h09 || d2_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d got=%h/%b exp=09/1", c, d2_out_data, d2_out_valid); end
    end
    d2_out_ready = 1'b1;
    #1;
    n_cmp++; if (d2_in_ready !== 2'b01) begin n_err++; $display("FAIL bp_refill_rdy got=%b exp=01", d2_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d2_out_data !== 5'h03 || d2_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_nobubble got=%h/%b exp=03/1", d2_out_data, d2_out_valid); end
    d2_in_valid = 2'b00;
  endtask

  task automatic test_rr_fair();
    logic [1:0] es;
    d4_mode = 1'b1; d4_in_data = {5'h13, 5'h12, 5'h11, 5'h10}; d4_in_valid = 4'b1111; d4_out_ready = 1'b1;
    #1;
    n_cmp++; if (d4_in_ready !== 4'b0001) begin n_err++; $display("FAIL rr_first_rdy got=%b exp=0001", d4_in_ready); end
    for (int k = 0; k < 5; k++) begin
      es = 2'(k);
      @(posedge clk); #1;
      n_cmp++; if (d4_out_src !== es || d4_out_data !== (5'h10 + {3'b000, es})) begin
        n_err++; $display("FAIL rr_seq%0d got=%0d/%h exp=%0d/%h", k, d4_out_src, d4_out_data, es, 5'h10 + {3'b000, es}); end
    end
  endtask

  task automatic test_skip_wrap();
    d4_in_valid = 4'b0100;
    #1;
    n_cmp++; if (d4_in_ready !== 4'b0100) begin n_err++; $display("FAIL sw_rdyA got=%b exp=0100", d4_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd2) begin n_err++; $display("FAIL sw_srcA got=%0d exp=2", d4_out_src); end
    d4_in_data = {5'h13, 5'h12, 5'h0A, 5'h10}; d4_in_valid = 4'b0010;
    #1;
    n_cmp++; if (d4_in_ready !== 4'b0010) begin n_err++; $display("FAIL sw_wrap_rdy got=%b exp=0010", d4_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd1 || d4_out_data !== 5'h0A) begin n_err++; $display("FAIL sw_wrap got=%0d/%h exp=1/0a", d4_out_src, d4_out_data); end
    d4_mode = 1'b0; d4_sel = 2'd0; d4_in_data = {5'h13, 5'h12, 5'h11, 5'h10}; d4_in_valid = 4'b1111;
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd0) begin n_err++; $display("FAIL sw_dir got=%0d exp=0", d4_out_src); end
    d4_mode = 1'b1;
    #1;
    n_cmp++; if (d4_in_ready !== 4'b0100) begin n_err++; $display("FAIL sw_ptr2_rdy got=%b exp=0100", d4_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd2 || d4_out_data !== 5'h12) begin n_err++; $display("FAIL sw_ptr2 got=%0d/%h exp=2/12", d4_out_src, d4_out_data); end
    d4_in_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_sel();
    d3_mode = 1'b0; d3_sel = 2'd2; d3_in_data = {5'h03, 5'h02, 5'h01}; d3_in_valid = 3'b111; d3_out_ready = 1'b1;
    #1;
    n_cmp++; if (d3_in_ready !== 3'b100) begin n_err++; $display("FAIL ill_rdy2 got=%b exp=100", d3_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d3_out_data !== 5'h03 || d3_out_src !== 2'd2) begin n_err++; $display("FAIL ill_load got=%h/%0d exp=03/2", d3_out_data, d3_out_src); end
    d3_sel = 2'd3;
    #1;
    n_cmp++; if (d3_in_ready !== 3'b000) begin n_err++; $display("FAIL ill_rdy3 got=%b exp=000", d3_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d3_out_valid !== 1'b0 || d3_out_data !== 5'h03) begin n_err++; $display("FAIL ill_drain got=%b/%h exp=0/03", d3_out_valid, d3_out_data); end
  endtask

  task automatic test_async_reset();
    d4_mode = 1'b1; d4_in_valid = 4'b1111; d4_out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd3) begin n_err++; $display("FAIL ar_pre3 got=%0d exp=3", d4_out_src); end
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd0 || d4_out_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre0 got=%0d/%b exp=0/1", d4_out_src, d4_out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd1 || d4_out_data !== 5'h11) begin n_err++; $display("FAIL ar_pre1 got=%0d/%h exp=1/11", d4_out_src, d4_out_data); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (d4_out_valid !== 1'b0 || d4_out_data !== 5'h00 || d4_out_src !== 2'd0) begin
      n_err++; $display("FAIL ar_immediate got=%b/%h/%0d exp=0/00/0", d4_out_valid, d4_out_data, d4_out_src); end
    @(posedge clk); #1;
    n_cmp++; if (d4_out_valid !== 1'b0) begin n_err++; $display("FAIL ar_held got=%b exp=0", d4_out_valid); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (d4_in_ready !== 4'b0001) begin n_err++; $display("FAIL ar_rr_rdy got=%b exp=0001", d4_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (d4_out_src !== 2'd0 || d4_out_data !== 5'h10 || d4_out_valid !== 1'b1) begin
      n_err++; $display("FAIL ar_rr_start got=%0d/%h/%b exp=0/10/1", d4_out_src, d4_out_data, d4_out_valid); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    d2_mode = 1'b0; d2_sel = 1'b0; d2_in_data = '0; d2_in_valid = '0; d2_out_ready = 1'b0;
    d3_mode = 1'b0; d3_sel = 2'd0; d3_in_data = '0; d3_in_valid = '0; d3_out_ready = 1'b0;
    d4_mode = 1'b0; d4_sel = 2'd0; d4_in_data = '0; d4_in_valid = '0; d4_out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_rr_fair();
    test_skip_wrap();
    test_illegal_sel();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 5, data bits per channel.
REQ-002 Parameter NUM_IN, default 2, number of input channels (2..16).
REQ-003 Parameter SEL_W, default 1, select/source index width = ceil(log2(NUM_IN)), minimum 1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = directed select, 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel index used in directed mode.
REQ-008 in_data  input  NUM_IN*WIDTH  flattened channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NUM_IN  per-channel data valid.
REQ-010 in_ready  output  NUM_IN  per-channel accept; one-hot or zero.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_src  output  SEL_W  index of channel that produced out_data.
REQ-013 out_valid  output  1  out_data/out_src hold a word.
REQ-014 out_ready  input  1  downstream accepts word this cycle.

Function
REQ-015 Transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both 1; output transfer where out_valid and out_ready are both 1.
REQ-016 Block SHALL have one output register; can_accept = !out_valid | out_ready (same-cycle drain and refill allowed).
REQ-017 Latency SHALL be 1 cycle: word accepted at edge N appears on out_data with out_valid=1 after edge N.
REQ-018 Directed mode: grant = sel when sel < NUM_IN and in_valid[sel]=1; otherwise no grant.
REQ-019 Directed mode with sel >= NUM_IN SHALL assert no in_ready and load nothing.
REQ-020 Round-robin mode: grant = first valid channel scanning from pointer ptr upward, wrapping NUM_IN-1 -> 0.
REQ-021 ptr SHALL update to (grant+1) mod NUM_IN only on an accepted transfer in round-robin mode; held otherwise, including throughout directed mode.
REQ-022 in_ready[i] SHALL equal (grant==i) & can_accept; combinational from current inputs and state, no in_valid dependency on other channels beyond the grant.
REQ-023 No valid inputs, or can_accept=0: all in_ready=0, output register and ptr unchanged.
REQ-024 Output drained with no new grant: out_valid SHALL fall to 0 next cycle; out_data/out_src hold last value.
REQ-025 Stall (out_valid=1, out_ready=0): out_data, out_src, out_valid SHALL remain stable.
REQ-026 mode and sel changes SHALL take effect in the same cycle; a word already in the output register is unaffected.

Reset
REQ-027 rst_n=0 SHALL immediately force out_valid=0, out_data=0, out_src=0, ptr=0, independent of clk.
REQ-028 Reset mid-transfer SHALL discard the held word; no transfer completes in a cycle where rst_n=0.
REQ-029 First grant after reset in round-robin mode SHALL start scanning from channel 0.

Structure
REQ-030 Shared package mux_pkg SHALL hold MODE_SEL=0, MODE_RR=1 constants and the clog2 helper function.
REQ-031 Round-robin grant logic (ptr register, wrap scan, pointer update) SHALL be sub-module rr_arbiter, parametrised by NUM_IN and SEL_W.
REQ-032 Datapath mux and output register SHALL reside in arb_mux top level; no latches, no combinational path from out_ready to out_data.

Verification
REQ-033 Directed: WIDTH=5, NUM_IN=2, mode=0, in_data ch0=0x07, ch1=0x08, both valid, out_ready=1, sel=0 then sel=1 -> out_data 0x07 (src 0) then 0x08 (src 1), each one cycle after acceptance.
REQ-034 Round-robin fairness: NUM_IN=4, all valid, ch i data = 0x10+i, out_ready=1, mode=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 Skip/wrap: NUM_IN=4, mode=1, ptr=3, only ch1 valid (data 0x0A) -> grant ch1, out_src=1, next ptr=2.
REQ-036 Backpressure: out_ready=0 for 3 cycles with word 0x09 held -> out_data stable 0x09, all in_ready=0; release -> refill same cycle, no bubble.
REQ-037 Illegal sel: NUM_IN=3, mode=0, sel=3 -> in_ready=0, out_valid falls after drain.
REQ-038 Async reset: assert rst_n=0 between clock edges while out_valid=1 -> out_valid, out_data, out_src=0 immediately; after release, round-robin starts at ch0.
